// File: rtl/peripheral_bfm_slave_generic_tl.sv
//------------------------------------------------------------------------------
// peripheral_bfm_slave_generic_tl: single-beat AXI-style slave over an internal
// word memory, with independent write (AW/W/B) and read (AR/R) engines.
//------------------------------------------------------------------------------
`default_nettype none

module peripheral_bfm_slave_generic_tl #(
  parameter int DEPTH = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_HAVE_ADDR = 2'd1,
    WR_HAVE_DATA = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  logic [31:0] mem_q [DEPTH];

  wr_state_e   wr_state_q, wr_state_d;
  logic [3:0]  awid_q, awid_d;
  logic [29:0] awidx_q, awidx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wlast_q, wlast_d;
  logic [1:0]  bresp_q, bresp_d;

  rd_state_e   rd_state_q, rd_state_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_commit, wr_ok, rd_in_range;

  // Byte-lane offsets are irrelevant to a word memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  assign awready = !areset && ((wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_DATA));
  assign wready  = !areset && ((wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_ADDR));
  assign arready = !areset && (rd_state_q == RD_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Write engine: the _d copies merge held captures with this edge's handshake,
  // so the commit below always sees a complete address/data pair.
  always_comb begin
    wr_state_d = wr_state_q;
    awid_d     = awid_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;

    if (aw_hs) begin
      awid_d  = awid;
      awidx_d = awaddr[31:2];
    end
    if (w_hs) begin
      wdata_d = wrdata;
      wstrb_d = wstrb;
      wlast_d = wlast;
    end

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = WR_RESP;
        else if (aw_hs)    wr_state_d = WR_HAVE_ADDR;
        else if (w_hs)     wr_state_d = WR_HAVE_DATA;
      end
      WR_HAVE_ADDR: if (w_hs)   wr_state_d = WR_RESP;
      WR_HAVE_DATA: if (aw_hs)  wr_state_d = WR_RESP;
      WR_RESP:      if (bready) wr_state_d = WR_IDLE;
      default:                  wr_state_d = WR_IDLE;
    endcase
  end

  assign wr_commit = (wr_state_q != WR_RESP) && (wr_state_d == WR_RESP);
  assign wr_ok     = ({2'b00, awidx_d} < 32'(DEPTH)) && wlast_d;

  always_comb begin
    bresp_d = bresp_q;
    if (wr_commit) bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
  end

  // Read engine: memory is sampled on the AR edge, before any same-edge write lands.
  assign rd_in_range = ({2'b00, araddr[31:2]} < 32'(DEPTH));

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rid_d      = arid;
          rdata_d    = rd_in_range ? mem_q[araddr[IDX_W+1:2]] : 32'h0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RD_DATA:  if (rready) rd_state_d = RD_IDLE;
      default:              rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      awid_q     <= '0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      bresp_q    <= '0;
      rd_state_q <= RD_IDLE;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awid_q     <= awid_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_commit && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_d[b]) mem_q[awidx_d[IDX_W-1:0]][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  assign bvalid = (wr_state_q == WR_RESP);
  assign bid    = bvalid ? awid_q  : 4'h0;
  assign bresp  = bvalid ? bresp_q : 2'b00;

  assign rvalid = (rd_state_q == RD_DATA);
  assign rid    = rvalid ? rid_q   : 4'h0;
  assign rdata  = rvalid ? rdata_q : 32'h0;
  assign rresp  = rvalid ? rresp_q : 2'b00;
  assign rlast  = rvalid;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_bfm_slave_generic_tl.sv
// Bench for peripheral_bfm_slave_generic_tl: transaction-level model plus
// directed literal scenarios and randomized concurrent read/write traffic.
`default_nettype none

module tb_peripheral_bfm_slave_generic_tl;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wrdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  always #5 aclk = ~aclk;

  peripheral_bfm_slave_generic_tl #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake never happened at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mmem [DEPTH];
  bit          m_haw, m_hw, m_bp, m_rp, m_wl, started;
  logic [3:0]  m_awid, m_bid, m_rid, m_ws;
  logic [31:0] m_awaddr, m_wd, m_rdata;
  logic [1:0]  m_bresp, m_rresp;
  logic        e_awready, e_wready, e_arready;

  assign e_awready = !areset && !m_haw && !m_bp;
  assign e_wready  = !areset && !m_hw && !m_bp;
  assign e_arready = !areset && !m_rp;

  always @(posedge aclk) begin
    int idx;
    started = 1'b1;
    if (areset) begin
      m_haw = 0; m_hw = 0; m_bp = 0; m_rp = 0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
    end else begin
      // read is resolved before the write so a same-edge commit is not seen
      if (m_rp) begin
        if (rready) m_rp = 0;
      end else if (arvalid) begin
        m_rp  = 1;
        m_rid = arid;
        idx   = int'(araddr >> 2);
        if (idx < DEPTH) begin m_rdata = mmem[idx]; m_rresp = 2'b00; end
        else             begin m_rdata = 32'h0;     m_rresp = 2'b10; end
      end
      if (m_bp) begin
        if (bready) m_bp = 0;
      end else begin
        if (awvalid && !m_haw) begin m_haw = 1; m_awid = awid; m_awaddr = awaddr; end
        if (wvalid && !m_hw)   begin m_hw = 1; m_wd = wrdata; m_ws = wstrb; m_wl = wlast; end
        if (m_haw && m_hw) begin
          m_haw = 0; m_hw = 0; m_bp = 1; m_bid = m_awid;
          idx = int'(m_awaddr >> 2);
          if (idx < DEPTH && m_wl) begin
            for (int b = 0; b < 4; b++)
              if (m_ws[b]) mmem[idx][8*b +: 8] = m_wd[8*b +: 8];
            m_bresp = 2'b00;
          end else begin
            m_bresp = 2'b10;
          end
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (started) begin
      chk("awready", awready, e_awready);
      chk("wready",  wready,  e_wready);
      chk("arready", arready, e_arready);
      chk("bvalid",  bvalid,  m_bp);
      chk("bid",     bid,     m_bp ? m_bid : 4'h0);
      chk("bresp",   bresp,   m_bp ? m_bresp : 2'b00);
      chk("rvalid",  rvalid,  m_rp);
      chk("rid",     rid,     m_rp ? m_rid : 4'h0);
      chk("rdata",   rdata,   m_rp ? m_rdata : 32'h0);
      chk("rresp",   rresp,   m_rp ? m_rresp : 2'b00);
      chk("rlast",   rlast,   m_rp);
    end
  end

  // ---------------- channel drivers (start and end at posedge+1) ----------------
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input int dly);
    bit hs = 0;
    repeat (dly) @(posedge aclk);
    if (dly > 0) #1;
    awid = id; awaddr = addr; awvalid = 1'b1;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge aclk); hs = e_awready;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0;
    if (!hs) timeout_fail("aw_timeout");
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l, input int dly);
    bit hs = 0;
    repeat (dly) @(posedge aclk);
    if (dly > 0) #1;
    wrdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge aclk); hs = e_wready;
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    if (!hs) timeout_fail("w_timeout");
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input int dly);
    bit hs = 0;
    repeat (dly) @(posedge aclk);
    if (dly > 0) #1;
    arid = id; araddr = addr; arvalid = 1'b1;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge aclk); hs = e_arready;
      @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    if (!hs) timeout_fail("ar_timeout");
  endtask

  task automatic b_recv(input int dly, output logic [3:0] oid, output logic [1:0] oresp);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge aclk); seen = m_bp;
    end
    oid = bid; oresp = bresp;
    if (!seen) begin timeout_fail("b_timeout"); return; end
    repeat (dly) @(negedge aclk);
    bready = 1'b1;
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic r_recv(input int dly, output logic [3:0] oid, output logic [31:0] od,
                        output logic [1:0] oresp);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge aclk); seen = m_rp;
    end
    oid = rid; od = rdata; oresp = rresp;
    if (!seen) begin timeout_fail("r_timeout"); return; end
    repeat (dly) @(negedge aclk);
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] d,
                    input logic [3:0] s, input logic l, input int awd, input int wd, input int bd,
                    output logic [3:0] oid, output logic [1:0] oresp);
    fork
      aw_send(id, addr, awd);
      w_send(d, s, l, wd);
    join
    b_recv(bd, oid, oresp);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input int rdly,
                    output logic [3:0] oid, output logic [31:0] od, output logic [1:0] oresp);
    ar_send(id, addr, 0);
    r_recv(rdly, oid, od, oresp);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'($urandom_range(0, DEPTH*4 + 15));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  oid;
    logic [1:0]  oresp;
    logic [31:0] od;

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("reset awready", awready, 1'b0);
    chk("reset bvalid",  bvalid,  1'b0);
    chk("reset rvalid",  rvalid,  1'b0);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    chk("post-reset awready", awready, 1'b1);
    chk("post-reset arready", arready, 1'b1);
    @(posedge aclk); #1;

    // basic write then read back
    fork
      aw_send(4'h7, 32'h4, 0);
      w_send(32'hDEADBEEF, 4'hF, 1'b1, 0);
    join
    @(negedge aclk); chk("b one-cycle latency", bvalid, 1'b1);
    b_recv(0, oid, oresp);
    chk("lit bid", oid, 4'h7);
    chk("lit bresp okay", oresp, 2'b00);
    ar_send(4'h2, 32'h4, 0);
    @(negedge aclk); chk("r one-cycle latency", rvalid, 1'b1);
    chk("lit rlast", rlast, 1'b1);
    r_recv(0, oid, od, oresp);
    chk("lit rdata", od, 32'hDEADBEEF);
    chk("lit rid", oid, 4'h2);
    chk("lit rresp", oresp, 2'b00);

    // W three cycles ahead of AW, partial strobes
    fork
      w_send(32'h12345678, 4'h3, 1'b1, 0);
      aw_send(4'h1, 32'h5, 3);
      begin
        @(posedge aclk);
        repeat (3) begin
          @(negedge aclk);
          chk("waiting awready", awready, 1'b1);
          chk("waiting wready", wready, 1'b0);
        end
      end
    join
    b_recv(0, oid, oresp);
    rd(4'h3, 32'h4, 0, oid, od, oresp);
    chk("lit partial strobe", od, 32'hDEAD5678);

    // out-of-range and wlast=0 errors
    wr(4'h4, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 0, 0, 0, oid, oresp);
    chk("lit oor bresp", oresp, 2'b10);
    rd(4'h4, 32'h40, 0, oid, od, oresp);
    chk("lit oor rresp", oresp, 2'b10);
    chk("lit oor rdata", od, 32'h0);
    wr(4'h5, 32'h0, 32'h55555555, 4'hF, 1'b0, 0, 0, 0, oid, oresp);
    chk("lit wlast0 bresp", oresp, 2'b10);
    rd(4'h5, 32'h0, 0, oid, od, oresp);
    chk("lit wlast0 no write", od, 32'h0);

    // same-edge write commit and read of the same word
    fork
      aw_send(4'h1, 32'h8, 0);
      w_send(32'hA5A5A5A5, 4'hF, 1'b1, 0);
      ar_send(4'h2, 32'h8, 0);
    join
    fork
      b_recv(1, oid, oresp);
      r_recv(0, oid, od, oresp);
    join
    chk("lit same-edge old data", od, 32'h0);
    rd(4'h2, 32'h8, 0, oid, od, oresp);
    chk("lit re-read new data", od, 32'hA5A5A5A5);

    // back-pressure: responses held while new requests wait
    fork
      aw_send(4'h3, 32'hC, 0);
      w_send(32'h11112222, 4'hF, 1'b1, 0);
    join
    awid = 4'h9; awaddr = 32'h10; awvalid = 1'b1;
    wrdata = 32'h33334444; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      chk("stall awready", awready, 1'b0);
      chk("stall bvalid", bvalid, 1'b1);
      chk("stall bid", bid, 4'h3);
    end
    bready = 1'b1;
    @(posedge aclk); #1 bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    chk("release awready", awready, 1'b1);
    chk("release bvalid", bvalid, 1'b0);
    @(posedge aclk); #1;
    ar_send(4'h5, 32'hC, 0);
    araddr = 32'h0; arvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      chk("stall arready", arready, 1'b0);
      chk("stall rdata", rdata, 32'h11112222);
      chk("stall rid", rid, 4'h5);
    end
    rready = 1'b1;
    @(posedge aclk); #1 rready = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    chk("release arready", arready, 1'b1);
    chk("release rvalid", rvalid, 1'b0);
    @(posedge aclk); #1;

    // reset while a write response is pending
    fork
      aw_send(4'h6, 32'h0, 0);
      w_send(32'hFFFFFFFF, 4'hF, 1'b1, 0);
    join
    areset = 1'b1;
    @(negedge aclk);
    chk("in-reset awready", awready, 1'b0);
    chk("in-reset wready", wready, 1'b0);
    chk("in-reset arready", arready, 1'b0);
    @(posedge aclk); #1 areset = 1'b0;
    @(negedge aclk);
    chk("reset drops bvalid", bvalid, 1'b0);
    chk("reset release awready", awready, 1'b1);
    chk("reset release wready", wready, 1'b1);
    chk("reset release arready", arready, 1'b1);
    @(posedge aclk); #1;
    rd(4'h1, 32'h0, 0, oid, od, oresp);
    chk("lit mem cleared 0", od, 32'h0);
    rd(4'h1, 32'h4, 0, oid, od, oresp);
    chk("lit mem cleared 4", od, 32'h0);

    // randomized concurrent traffic
    fork
      begin
        logic [3:0]  wid;
        logic [1:0]  wresp;
        for (int i = 0; i < 200; i++) begin
          wr(4'($urandom), rand_addr(), $urandom, 4'($urandom), ($urandom_range(0, 7) != 0),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wid, wresp);
        end
      end
      begin
        logic [3:0]  xid;
        logic [31:0] xd;
        logic [1:0]  xresp;
        for (int j = 0; j < 250; j++) begin
          rd(4'($urandom), rand_addr(), $urandom_range(0, 3), xid, xd, xresp);
        end
      end
    join

    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
